// File: rtl/demux8_4b_reg_pkg.sv
// -----------------------------------------------------------------------------
// demux8_4b_reg_pkg
// Shared constants for the registered 1-to-8 nibble distributor:
//   SLOTS    - number of output slots (8)
//   PTR_W    - width of a slot index / auto-write pointer (3)
//   SLOT_RST - value every slot register returns to on Reset/Clear (0)
// plus the slot-index to one-hot write-enable decoder.
// -----------------------------------------------------------------------------
package demux8_4b_reg_pkg;

  localparam int SLOTS    = 8;
  localparam int PTR_W    = 3;
  localparam int SLOT_RST = 0;

  // 3-to-8 one-hot decode of a slot index.
  function automatic logic [SLOTS-1:0] dec_onehot(input logic [PTR_W-1:0] idx);
    return SLOTS'(1) << idx;
  endfunction

endpackage

// File: rtl/demux8_4b_reg_slot_reg_en.sv
// -----------------------------------------------------------------------------
// slot_reg_en
// One slot of the distributor bank: a WIDTH-bit register with synchronous
// clear, load enable and a sticky valid bit set by any write.
// Ports:
//   clk_i  - rising-edge clock
//   clr_i  - synchronous clear (Reset or Clear); wins over we_i
//   we_i   - write enable for this slot
//   d_i    - write data
//   q_o    - registered slot contents
//   vld_o  - slot written since last clear
// -----------------------------------------------------------------------------
module slot_reg_en
  import demux8_4b_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q <= WIDTH'(SLOT_RST);
      vld_q  <= 1'b0;
    end else if (we_i) begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/demux8_4b_reg.sv
// -----------------------------------------------------------------------------
// demux8_4b_reg
// Registered 1-to-8 distributor for WIDTH-bit data. Each Load writes D into
// one slot, chosen by {S2,S1,S0} (Auto=0) or by the internal ring pointer Ptr
// (Auto=1, Ptr then advances modulo 8). Priority per edge: Reset > Clear > Load.
// Ports:
//   Clock          - rising-edge clock
//   Reset          - synchronous active-high reset
//   D              - write data
//   S2,S1,S0       - explicit slot select (Auto=0 only)
//   Load           - write strobe, one write per cycle
//   Auto           - 1: write slot Ptr, 0: write slot {S2,S1,S0}
//   Clear          - synchronous flush, same effect as Reset
//   Q0..Q7         - registered slot contents
//   Valid          - bit i set when slot i written since Reset/Clear
//   Ptr            - next auto-write slot
//   Full           - all Valid bits set
//   Overflow       - one-cycle pulse: Auto write hit an already-valid slot
// -----------------------------------------------------------------------------
module demux8_4b_reg
  import demux8_4b_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic             Load,
  input  logic             Auto,
  input  logic             Clear,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic [7:0]       Valid,
  output logic [2:0]       Ptr,
  output logic             Full,
  output logic             Overflow
);

  logic             flush;
  logic [PTR_W-1:0] sel;
  logic [SLOTS-1:0] we;
  logic [SLOTS-1:0] vld;
  logic [WIDTH-1:0] slot_q [SLOTS];

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;

  assign flush = Reset | Clear;

  // Select is only decoded under Load, so an undriven S2..S0 while idle
  // never reaches a write enable.
  assign sel = Auto ? ptr_q : {S2, S1, S0};

  always_comb begin
    we    = '0;
    ptr_d = ptr_q;
    ovf_d = 1'b0;
    if (Load) begin
      we = dec_onehot(sel);
      if (Auto) begin
        ptr_d = ptr_q + PTR_W'(1);
        ovf_d = vld[ptr_q];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (flush) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    slot_reg_en #(.WIDTH(WIDTH)) u_slot (
      .clk_i (Clock),
      .clr_i (flush),
      .we_i  (we[i]),
      .d_i   (D),
      .q_o   (slot_q[i]),
      .vld_o (vld[i])
    );
  end

  assign Q0       = slot_q[0];
  assign Q1       = slot_q[1];
  assign Q2       = slot_q[2];
  assign Q3       = slot_q[3];
  assign Q4       = slot_q[4];
  assign Q5       = slot_q[5];
  assign Q6       = slot_q[6];
  assign Q7       = slot_q[7];
  assign Valid    = vld;
  assign Ptr      = ptr_q;
  assign Full     = &vld;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_demux8_4b_reg.sv
module tb_demux8_4b_reg;

  logic       Clock = 1'b0;
  logic       Reset, Load, Auto, Clear, S2, S1, S0;
  logic [3:0] D;
  logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [7:0] Valid;
  logic [2:0] Ptr;
  logic       Full, Overflow;

  int checks   = 0;
  int failures = 0;

  demux8_4b_reg #(.WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .D(D), .S2(S2), .S1(S1), .S0(S0),
    .Load(Load), .Auto(Auto), .Clear(Clear),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
    .Valid(Valid), .Ptr(Ptr), .Full(Full), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs can be sampled away from it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_sel(input logic [2:0] s);
    {S2, S1, S0} = s;
  endtask

  function automatic logic [31:0] qpack();
    return {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};
  endfunction

  initial begin
    Reset = 1'b1; Load = 1'b1; Auto = 1'b1; Clear = 1'b0; D = 4'hF;
    set_sel(3'd0);

    // Reset with Load held: nothing written
    step();
    chk("rst_q",     qpack(), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h00);
    chk("rst_ptr",   32'(Ptr), 32'd0);
    chk("rst_full",  32'(Full), 32'd0);
    chk("rst_ovf",   32'(Overflow), 32'd0);
    Reset = 1'b0; Load = 1'b0;
    step();

    // Explicit writes
    Auto = 1'b0; Load = 1'b1; D = 4'h3; set_sel(3'd5);
    step();
    chk("exp_ovf0", 32'(Overflow), 32'd0);
    D = 4'hA; set_sel(3'd0);
    step();
    chk("exp_ovf1", 32'(Overflow), 32'd0);
    Load = 1'b0;
    step();
    chk("exp_q",     qpack(), 32'h0030_000A);
    chk("exp_valid", 32'(Valid), 32'h21);
    chk("exp_ptr",   32'(Ptr), 32'd0);

    // Load=0 with arbitrary select must not disturb anything
    for (int i = 0; i < 4; i++) begin
      set_sel(3'($urandom_range(0, 7)));
      D = 4'($urandom_range(0, 15));
      step();
    end
    chk("idle_q",     qpack(), 32'h0030_000A);
    chk("idle_valid", 32'(Valid), 32'h21);

    // Clear, then auto fill 1..8
    Clear = 1'b1;
    step();
    chk("clr_valid", 32'(Valid), 32'h00);
    Clear = 1'b0; Auto = 1'b1; Load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D = 4'(i + 1);
      step();
      chk($sformatf("fill_ovf%0d", i), 32'(Overflow), 32'd0);
      if (i == 6) chk("fill_full_early", 32'(Full), 32'd0);
    end
    chk("fill_q",     qpack(), 32'h8765_4321);
    chk("fill_valid", 32'(Valid), 32'hFF);
    chk("fill_ptr",   32'(Ptr), 32'd0);
    chk("fill_full",  32'(Full), 32'd1);

    // Wrap: ring overwrite of slot 0
    D = 4'hC;
    step();
    chk("wrap_q",    qpack(), 32'h8765_432C);
    chk("wrap_ptr",  32'(Ptr), 32'd1);
    chk("wrap_ovf",  32'(Overflow), 32'd1);
    Load = 1'b0;
    step();
    chk("wrap_ovf_drop", 32'(Overflow), 32'd0);
    chk("wrap_full",     32'(Full), 32'd1);

    // Explicit overwrite while full: silent
    Auto = 1'b0; Load = 1'b1; D = 4'hE; set_sel(3'd7);
    step();
    chk("fullexp_q",   qpack(), 32'hE765_432C);
    chk("fullexp_ovf", 32'(Overflow), 32'd0);
    chk("fullexp_ptr", 32'(Ptr), 32'd1);

    // Two more auto writes to bring Ptr to 3
    Auto = 1'b1; D = 4'h9;
    step();
    step();
    chk("pre_clr_ptr", 32'(Ptr), 32'd3);
    chk("pre_clr_ovf", 32'(Overflow), 32'd1);

    // Clear with Load in the same cycle
    Clear = 1'b1; D = 4'h5;
    step();
    chk("clrld_q",     qpack(), 32'h0);
    chk("clrld_valid", 32'(Valid), 32'h00);
    chk("clrld_ptr",   32'(Ptr), 32'd0);
    chk("clrld_ovf",   32'(Overflow), 32'd0);
    Clear = 1'b0; D = 4'h7;
    step();
    chk("post_clr_q",     qpack(), 32'h0000_0007);
    chk("post_clr_valid", 32'(Valid), 32'h01);
    chk("post_clr_ptr",   32'(Ptr), 32'd1);

    // Mixed modes
    Load = 1'b0; Clear = 1'b1;
    step();
    Clear = 1'b0; Load = 1'b1; Auto = 1'b1; D = 4'h1;
    step();
    Auto = 1'b0; D = 4'h2; set_sel(3'd6);
    step();
    chk("mix_ptr_hold", 32'(Ptr), 32'd1);
    Auto = 1'b1; D = 4'h3;
    step();
    Load = 1'b0;
    chk("mix_q",     qpack(), 32'h0200_0031);
    chk("mix_ptr",   32'(Ptr), 32'd2);
    chk("mix_valid", 32'(Valid), 32'h43);
    chk("mix_full",  32'(Full), 32'd0);
    chk("mix_ovf",   32'(Overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux8_4b_reg.md
Name: demux8_4b_reg

Overview:
- Registered 1-to-8 distributor for 4-bit data: the write-side counterpart of the team's 8:1 4-bit selector.
- Captures a nibble into one of eight output slots, chosen either by an explicit 3-bit select or by an internal auto-increment pointer.
- Feeds the slot bank that downstream selectors and display logic read from.
- Tracks per-slot valid bits, a full flag and an overwrite pulse.

Parameters:
- WIDTH, 4, data width of each slot and of D.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- D  input  WIDTH  write data.
- S2, S1, S0  input  1 each  explicit slot select, {S2,S1,S0}; used only when Auto=0.
- Load  input  1  write strobe; one write per cycle while high.
- Auto  input  1  1 = write to internal pointer Ptr; 0 = write to {S2,S1,S0}.
- Clear  input  1  synchronous flush of all slots.
- Q0..Q7  output  WIDTH each  registered slot contents.
- Valid  output  8  bit i = slot i written since last Reset/Clear.
- Ptr  output  3  next auto-write slot index.
- Full  output  1  all eight Valid bits set.
- Overflow  output  1  one-cycle pulse: an Auto write landed on an already-valid slot.

Behaviour:
- Clock and reset: one clock domain; Reset is synchronous, active-high.
- Reset values: Q0..Q7=0, Valid=8'h00, Ptr=0, Overflow=0, Full=0.
- Priority per edge: Reset > Clear > Load.
- Clear=1: same effect as Reset on all outputs. A Load in the same cycle is dropped.
- Load=1, Auto=0, target k={S2,S1,S0}:
  - Qk<=D and Valid[k]<=1 at the edge.
  - Other slots and Ptr are unchanged.
  - Overflow<=0.
- Load=1, Auto=1, target k=Ptr:
  - Qk<=D, Valid[k]<=1, Ptr<=Ptr+1 (modulo 8; 7 wraps to 0).
  - Overflow<=Valid[k] (value before the edge).
- Load=0: all slot state holds; Overflow<=0.
- Latency: written data is visible on Qk the cycle after the Load edge. A slot can be rewritten every cycle.
- Full: combinational AND of the registered Valid bits, so it asserts the cycle after the eighth distinct slot is written.
- Full=1 does not block writes:
  - Explicit mode overwrites silently.
  - Auto mode overwrites ring-style and pulses Overflow.
- Mode switching: changing Auto mid-stream is legal.
  - Explicit writes never move Ptr.
  - Auto writes ignore S2..S0.
- Reset or Clear mid-stream: the next Auto write goes to slot 0.
- X on S2..S0 while Load=0 must not corrupt state.

Decomposition:
- Shared include: slot count (8), pointer width (3), reset value of slots (0).
- One natural sub-module, slot_reg_en: WIDTH-bit register with synchronous clear, load enable and valid bit. Instantiated 8 times behind a 3-to-8 one-hot write decoder in the top.

Test Plan:
- Reset with Load=1, D=4'hF held -> all Q=0, Valid=00, Ptr=0, Full=0 after the edge; no write occurs.
- Explicit writes: Auto=0, write D=4'h3 to sel 5, then 4'hA to sel 0 -> Q5=3, Q0=A, Valid=8'h21, Ptr=0, Overflow never pulses.
- Auto fill: Auto=1, Load for 8 cycles with D=1..8 -> Qi=i+1, Ptr wraps to 0, Valid=FF, Full=1 one cycle after the 8th write.
- Auto wrap: after the full fill, one more write D=4'hC -> Q0=C, Ptr=1, Overflow=1 for exactly one cycle.
- Clear with Load in the same cycle (Auto=1, Ptr=3) -> all Q=0, Valid=00, Ptr=0, no write; the next Auto write of D=4'h7 lands in Q0.
- Mixed modes: Auto write to slot 0, explicit write to slot 6, Auto write -> lands in slot 1, Ptr=2, Valid=8'h43.
